// File: rtl/mdu_seq.sv
// mdu_seq: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with MTHI/MTLO writes.
// Optional MDU_EARLY_OUT_EN ends a multiply early once the remaining multiplier bits are zero.
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_n;
  logic is_div, neg_p, neg_r, dz, sgn, b_zero, last, early;
  logic [2*WIDTH-1:0] acc, acc_n, acc_load, prod;
  logic [WIDTH-1:0] opb, ua, ub, quo, rem;
  logic [WIDTH:0] sum, shifted, diff;
  logic [CW-1:0] cnt;
  assign sgn = !op[0];
  assign b_zero = b == '0;
  assign ua = (sgn && a[WIDTH-1]) ? -a : a;
  assign ub = (sgn && b[WIDTH-1]) ? -b : b;
  assign busy = state != IDLE;
  assign last = cnt == CW'(WIDTH-1);
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb};
    shifted = acc[2*WIDTH-1:WIDTH-1];
    diff = shifted - {1'b0, opb};
    acc_n = is_div ? {diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0], acc[WIDTH-2:0], !diff[WIDTH]}
                   : acc[0] ? {sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    prod = neg_p ? -acc : acc;
    quo = neg_p ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end
`ifdef MDU_EARLY_OUT_EN
  logic [CW:0] left;
  // Bits still unshifted sit at the bottom; if zero, only plain shifts remain, so do them at once.
  always_comb begin
    left = (CW+1)'(WIDTH-1) - {1'b0, cnt};
    early = !is_div && ((acc_n[WIDTH-1:0] << ((CW+1)'(WIDTH) - left)) == '0);
    acc_load = early ? acc_n >> left : acc_n;
  end
`else
  assign early = 1'b0;
  assign acc_load = acc_n;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (state == IDLE && start) state_n = (op[1] && b_zero) ? FIX : RUN;
    else if (state == RUN && (last || early)) state_n = FIX;
    else if (state == FIX) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {is_div, neg_p, neg_r, dz, done, div_zero} <= '0;
      acc <= '0;
      opb <= '0;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
    end else begin
      done <= 1'b0;
      div_zero <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          is_div <= op[1];
          dz <= op[1] && b_zero;
          neg_p <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_r <= sgn && a[WIDTH-1];
          acc <= {{WIDTH{1'b0}}, (op[1] && b_zero) ? a : op[1] ? ua : ub};
          opb <= op[1] ? ub : ua;
          cnt <= '0;
        end else begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
        end
      end else if (state == RUN) begin
        acc <= acc_load;
        cnt <= cnt + 1'b1;
      end else begin
        done <= 1'b1;
        div_zero <= dz;
        hi <= dz ? acc[WIDTH-1:0] : is_div ? rem : prod[2*WIDTH-1:WIDTH];
        lo <= dz ? '1 : is_div ? quo : prod[WIDTH-1:0];
      end
    end
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: randomized and directed checks of mdu_seq against an arithmetic reference model.
module tb_mdu_seq;
  localparam int W = 32;
  logic clk = 0, rst_n = 0, start = 0, hi_we = 0, lo_we = 0;
  logic [1:0] op = 0;
  logic [W-1:0] a = 0, b = 0, wdata = 0;
  logic busy, done, div_zero;
  logic [W-1:0] hi, lo;
  int checks = 0, errors = 0;

  mdu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo));

  always #5 clk = ~clk;

  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] eh, output logic [31:0] el, output logic edz);
    longint p, q, r;
    edz = 0;
    if (!o[1]) begin
      p = o[0] ? longint'({32'b0, x}) * longint'({32'b0, y})
               : longint'($signed(x)) * longint'($signed(y));
      eh = p[63:32];
      el = p[31:0];
    end else if (y == 0) begin
      eh = x;
      el = '1;
      edz = 1;
    end else begin
      q = o[0] ? longint'({32'b0, x}) / longint'({32'b0, y}) : longint'($signed(x)) / longint'($signed(y));
      r = o[0] ? longint'({32'b0, x}) % longint'({32'b0, y}) : longint'($signed(x)) % longint'($signed(y));
      el = q[31:0];
      eh = r[31:0];
    end
  endfunction

  // Launch one op; lat = edges after the accepting edge until done seen, bcnt = busy samples.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int poke,
                        output int lat, output int bcnt, output logic rdz);
    op = o; a = x; b = y; start = 1;
    @(posedge clk); #1;
    start = 0; op = 2'($urandom); a = $urandom; b = $urandom;
    lat = 0; bcnt = int'(busy); rdz = 0;
    while (lat < 100) begin
      if (lat == poke) start = 1;
      @(posedge clk); #1;
      start = 0;
      lat++;
      bcnt += int'(busy);
      if (done) begin
        rdz = div_zero;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    #1;
    checks++;
    if ({busy, done, div_zero, hi, lo} !== '0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b dz=%b hi=%h lo=%h, required all zero", busy, done, div_zero, hi, lo);
    end
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_mul;
    int lat, bcnt; logic rdz, edz; logic [31:0] eh, el, x, y; logic [1:0] o;
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, lat, bcnt, rdz);
    checks++;
    if ({hi, lo, rdz} !== {32'hFFFFFFFE, 32'h00000001, 1'b0} || lat != 33 || bcnt != 33) begin
      errors++;
      $display("FAIL multu_max: hi=%h lo=%h dz=%b lat=%0d busy=%0d, required fffffffe 00000001 0 33 33", hi, lo, rdz, lat, bcnt);
    end
    run_op(2'b00, 32'hFFFFFFFD, 32'd7, 5, lat, bcnt, rdz);
    checks++;
    if ({hi, lo} !== {32'hFFFFFFFF, 32'hFFFFFFEB} || lat != 33) begin
      errors++;
      $display("FAIL mult_neg_restart: hi=%h lo=%h lat=%0d, required ffffffff ffffffeb 33", hi, lo, lat);
    end
    for (int i = 0; i < 12; i++) begin
      o = {1'b0, 1'($urandom)}; x = $urandom; y = (i < 3) ? 32'($urandom_range(0, 15)) : $urandom;
      model(o, x, y, eh, el, edz);
      run_op(o, x, y, -1, lat, bcnt, rdz);
      checks++;
      if ({hi, lo, rdz} !== {eh, el, edz} || lat != 33) begin
        errors++;
        $display("FAIL mul_rand op=%0d a=%h b=%h: hi=%h lo=%h lat=%0d, required %h %h 33", o, x, y, hi, lo, lat, eh, el);
      end
    end
  endtask

  task automatic test_div;
    int lat, bcnt; logic rdz, edz; logic [31:0] eh, el, x, y; logic [1:0] o;
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, -1, lat, bcnt, rdz);
    checks++;
    if ({hi, lo, rdz} !== {32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0} || lat != 33) begin
      errors++;
      $display("FAIL div_neg: hi=%h lo=%h lat=%0d, required ffffffff fffffffd 33", hi, lo, lat);
    end
    run_op(2'b11, 32'd7, 32'd2, -1, lat, bcnt, rdz);
    checks++;
    if ({hi, lo} !== {32'd1, 32'd3} || lat != 33) begin
      errors++;
      $display("FAIL divu_7_2: hi=%h lo=%h lat=%0d, required 1 3 33", hi, lo, lat);
    end
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, -1, lat, bcnt, rdz);
    checks++;
    if ({hi, lo, rdz} !== {32'h0, 32'h80000000, 1'b0}) begin
      errors++;
      $display("FAIL div_overflow: hi=%h lo=%h dz=%b, required 0 80000000 0", hi, lo, rdz);
    end
    for (int i = 0; i < 12; i++) begin
      o = {1'b1, 1'($urandom)}; x = $urandom; y = (i < 4) ? 32'($urandom_range(1, 300)) : $urandom;
      model(o, x, y, eh, el, edz);
      run_op(o, x, y, -1, lat, bcnt, rdz);
      checks++;
      if ({hi, lo, rdz} !== {eh, el, edz} || lat != 33) begin
        errors++;
        $display("FAIL div_rand op=%0d a=%h b=%h: hi=%h lo=%h lat=%0d, required %h %h 33", o, x, y, hi, lo, lat, eh, el);
      end
    end
  endtask

  task automatic test_div_zero;
    int lat, bcnt; logic rdz;
    run_op(2'b11, 32'd5, 32'd0, -1, lat, bcnt, rdz);
    checks++;
    if ({hi, lo, rdz} !== {32'd5, 32'hFFFFFFFF, 1'b1} || lat != 1 || bcnt != 1) begin
      errors++;
      $display("FAIL divu_zero: hi=%h lo=%h dz=%b lat=%0d busy=%0d, required 5 ffffffff 1 1 1", hi, lo, rdz, lat, bcnt);
    end
    run_op(2'b10, 32'hFFFFFF00, 32'd0, -1, lat, bcnt, rdz);
    checks++;
    if ({hi, lo, rdz} !== {32'hFFFFFF00, 32'hFFFFFFFF, 1'b1} || lat != 1) begin
      errors++;
      $display("FAIL div_zero_neg: hi=%h lo=%h dz=%b lat=%0d, required ffffff00 ffffffff 1 1", hi, lo, rdz, lat);
    end
  endtask

  task automatic test_mthi_mtlo;
    logic [31:0] old;
    int n;
    hi_we = 1; wdata = 32'h1234;
    @(posedge clk); #1;
    hi_we = 0; lo_we = 1; wdata = 32'hABCD;
    checks++;
    if (hi !== 32'h1234) begin errors++; $display("FAIL mthi: hi=%h, required 00001234", hi); end
    @(posedge clk); #1;
    lo_we = 0;
    checks++;
    if ({hi, lo} !== {32'h1234, 32'hABCD}) begin errors++; $display("FAIL mtlo: hi=%h lo=%h, required 1234 abcd", hi, lo); end
    hi_we = 1; lo_we = 1; wdata = 32'h55AA55AA;
    @(posedge clk); #1;
    hi_we = 0; lo_we = 0;
    checks++;
    if ({hi, lo} !== {32'h55AA55AA, 32'h55AA55AA}) begin errors++; $display("FAIL mthi_mtlo_both: hi=%h lo=%h, required 55aa55aa x2", hi, lo); end
    op = 2'b01; a = 3; b = 5; start = 1;
    @(posedge clk); #1;
    start = 0; old = lo; lo_we = 1; wdata = 32'hDEAD;
    @(posedge clk); #1;
    lo_we = 0;
    checks++;
    if (lo !== old) begin errors++; $display("FAIL mtlo_busy: lo=%h, required %h", lo, old); end
    n = 0;
    while (!done && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if ({hi, lo, done} !== {32'd0, 32'd15, 1'b1}) begin errors++; $display("FAIL mtlo_busy_result: hi=%h lo=%h done=%b, required 0 f 1", hi, lo, done); end
    @(posedge clk); #1;
    old = hi;
    op = 2'b01; a = 2; b = 3; start = 1; hi_we = 1; wdata = 32'h77777777;
    @(posedge clk); #1;
    start = 0; hi_we = 0;
    checks++;
    if (hi !== old || busy !== 1'b1) begin errors++; $display("FAIL start_beats_mthi: hi=%h busy=%b, required %h 1", hi, busy, old); end
    n = 0;
    while (!done && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if ({hi, lo, done} !== {32'd0, 32'd6, 1'b1}) begin errors++; $display("FAIL start_beats_mthi_result: hi=%h lo=%h done=%b, required 0 6 1", hi, lo, done); end
  endtask

  task automatic test_reset_midrun;
    int lat, bcnt, pulses; logic rdz;
    op = 2'b10; a = 32'h12345678; b = 32'd3; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 0;
    #1;
    checks++;
    if ({busy, done, hi, lo} !== '0) begin
      errors++;
      $display("FAIL reset_midrun: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi, lo);
    end
    @(posedge clk); #1;
    rst_n = 1;
    pulses = 0;
    repeat (40) begin @(posedge clk); #1; pulses += int'(done); end
    checks++;
    if (pulses != 0 || busy !== 1'b0) begin errors++; $display("FAIL reset_no_done: pulses=%0d busy=%b, required 0 0", pulses, busy); end
    run_op(2'b11, 32'd100, 32'd7, -1, lat, bcnt, rdz);
    checks++;
    if ({hi, lo} !== {32'd2, 32'd14} || lat != 33) begin
      errors++;
      $display("FAIL after_reset_op: hi=%h lo=%h lat=%0d, required 2 e 33", hi, lo, lat);
    end
  endtask

  task automatic test_random;
    int lat, bcnt; logic rdz, edz; logic [31:0] eh, el, x, y; logic [1:0] o;
    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom); x = $urandom; y = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      model(o, x, y, eh, el, edz);
      run_op(o, x, y, (i % 5 == 0) ? 7 : -1, lat, bcnt, rdz);
      checks++;
      if ({hi, lo, rdz} !== {eh, el, edz} || lat != (edz ? 1 : 33)) begin
        errors++;
        $display("FAIL random op=%0d a=%h b=%h: hi=%h lo=%h dz=%b lat=%0d, required %h %h %b", o, x, y, hi, lo, rdz, lat, eh, el, edz);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_mthi_mtlo();
    test_reset_midrun();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
